// File: rtl/jtag_tap_sync_if.sv
// Pad-side and debug-chain signals of the JTAG TAP responder.
// slave modport is the TAP itself; master is the pad driver / debug unit side.
interface jtag_tap_sync_if;
    logic tck_pad_i;
    logic tms_pad_i;
    logic tdi_pad_i;
    logic tdo_pad_o;
    logic tdo_oe_o;
    logic debug_select_o;
    logic capture_dr_o;
    logic shift_dr_o;
    logic update_dr_o;
    logic debug_tdi_o;
    logic debug_tdo_i;

    modport slave (
        input  tck_pad_i,
        input  tms_pad_i,
        input  tdi_pad_i,
        input  debug_tdo_i,
        output tdo_pad_o,
        output tdo_oe_o,
        output debug_select_o,
        output capture_dr_o,
        output shift_dr_o,
        output update_dr_o,
        output debug_tdi_o
    );

    modport master (
        output tck_pad_i,
        output tms_pad_i,
        output tdi_pad_i,
        output debug_tdo_i,
        input  tdo_pad_o,
        input  tdo_oe_o,
        input  debug_select_o,
        input  capture_dr_o,
        input  shift_dr_o,
        input  update_dr_o,
        input  debug_tdi_o
    );
endinterface

// File: rtl/jtag_tap_sync.sv
// IEEE 1149.1 TAP oversampled in wb_clk_i: IR, IDCODE, BYPASS, DEBUG chain (USERCODE DR with JTAG_TAP_USERCODE_EN).
// Latency: tdi reaches a register 3 wb_clk after tck rise; tdo registered 3 wb_clk after tck fall.
// Backpressure: none; tck high and low phases must each span at least 3 wb_clk cycles.
module jtag_tap_sync #(
    parameter int          IR_WIDTH       = 4,
    parameter logic [31:0] IDCODE_VALUE   = 32'h14951185
`ifdef JTAG_TAP_USERCODE_EN
    ,
    parameter logic [31:0] USERCODE_VALUE = 32'h0
`endif
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    jtag_tap_sync_if.slave   jtag
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS, DR_IDCODE, DR_DEBUG, DR_USER
    } dr_sel_t;

    logic tck_s1, tck_s2, tck_s3;
    logic tms_s1, tms_s2;
    logic tdi_s1, tdi_s2;
    logic tck_rise, tck_fall;

    tap_state_t state, state_nxt;

    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] shift_ir;
    logic [31:0]         idcode_sr;
    logic                bypass_sr;
`ifdef JTAG_TAP_USERCODE_EN
    logic [31:0]         usercode_sr;
`endif

    dr_sel_t dr_sel;
    logic    dr_tdo;
    logic    dbg_sel;

    logic tdo_q, tdo_oe_q;
    logic capture_q, shift_q, update_q;
    logic debug_tdi_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tck_s1 <= 1'b0;
            tck_s2 <= 1'b0;
            tck_s3 <= 1'b0;
            tms_s1 <= 1'b0;
            tms_s2 <= 1'b0;
            tdi_s1 <= 1'b0;
            tdi_s2 <= 1'b0;
        end else begin
            tck_s1 <= jtag.tck_pad_i;
            tck_s2 <= tck_s1;
            tck_s3 <= tck_s2;
            tms_s1 <= jtag.tms_pad_i;
            tms_s2 <= tms_s1;
            tdi_s1 <= jtag.tdi_pad_i;
            tdi_s2 <= tdi_s1;
        end
    end

    assign tck_rise = tck_s2 & ~tck_s3;
    assign tck_fall = ~tck_s2 & tck_s3;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= TLR;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tck_rise) begin
            case (state)
                TLR:      state_nxt = tms_s2 ? TLR      : RTI;
                RTI:      state_nxt = tms_s2 ? SEL_DR   : RTI;
                SEL_DR:   state_nxt = tms_s2 ? SEL_IR   : CAP_DR;
                CAP_DR:   state_nxt = tms_s2 ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR: state_nxt = tms_s2 ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR: state_nxt = tms_s2 ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state_nxt = tms_s2 ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: state_nxt = tms_s2 ? UPD_DR   : SHIFT_DR;
                UPD_DR:   state_nxt = tms_s2 ? SEL_DR   : RTI;
                SEL_IR:   state_nxt = tms_s2 ? TLR      : CAP_IR;
                CAP_IR:   state_nxt = tms_s2 ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR: state_nxt = tms_s2 ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR: state_nxt = tms_s2 ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state_nxt = tms_s2 ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: state_nxt = tms_s2 ? UPD_IR   : SHIFT_IR;
                UPD_IR:   state_nxt = tms_s2 ? SEL_DR   : RTI;
                default:  state_nxt = TLR;
            endcase
        end
    end

    // Unlisted instruction codes fall through to BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir == IR_WIDTH'(4'h1))
            dr_sel = DR_IDCODE;
        else if (ir == IR_WIDTH'(4'h8))
            dr_sel = DR_DEBUG;
`ifdef JTAG_TAP_USERCODE_EN
        else if (ir == IR_WIDTH'(4'h7))
            dr_sel = DR_USER;
`endif
    end

    assign dbg_sel = (dr_sel == DR_DEBUG);

    always_comb begin
        dr_tdo = bypass_sr;
        case (dr_sel)
            DR_IDCODE: dr_tdo = idcode_sr[0];
            DR_DEBUG:  dr_tdo = jtag.debug_tdo_i;
`ifdef JTAG_TAP_USERCODE_EN
            DR_USER:   dr_tdo = usercode_sr[0];
`endif
            default:   dr_tdo = bypass_sr;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ir          <= IR_WIDTH'(1);
            shift_ir    <= '0;
            idcode_sr   <= '0;
            bypass_sr   <= 1'b0;
`ifdef JTAG_TAP_USERCODE_EN
            usercode_sr <= '0;
`endif
        end else if (tck_rise) begin
            case (state)
                CAP_IR:   shift_ir <= IR_WIDTH'(1);
                SHIFT_IR: shift_ir <= {tdi_s2, shift_ir[IR_WIDTH-1:1]};
                UPD_IR:   ir       <= shift_ir;
                CAP_DR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_sr   <= IDCODE_VALUE;
                        DR_BYPASS: bypass_sr   <= 1'b0;
`ifdef JTAG_TAP_USERCODE_EN
                        DR_USER:   usercode_sr <= USERCODE_VALUE;
`endif
                        default: ;
                    endcase
                end
                SHIFT_DR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_sr   <= {tdi_s2, idcode_sr[31:1]};
                        DR_BYPASS: bypass_sr   <= tdi_s2;
`ifdef JTAG_TAP_USERCODE_EN
                        DR_USER:   usercode_sr <= {tdi_s2, usercode_sr[31:1]};
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
            if (state_nxt == TLR)
                ir <= IR_WIDTH'(1);
        end
    end

    // Strobes are single-cycle and mutually exclusive because state holds one value per tck_rise.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            capture_q   <= 1'b0;
            shift_q     <= 1'b0;
            update_q    <= 1'b0;
            debug_tdi_q <= 1'b0;
        end else begin
            capture_q <= tck_rise && dbg_sel && (state == CAP_DR);
            shift_q   <= tck_rise && dbg_sel && (state == SHIFT_DR);
            update_q  <= tck_rise && dbg_sel && (state == UPD_DR);
            if (tck_rise && state == SHIFT_DR)
                debug_tdi_q <= tdi_s2;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else if (tck_fall) begin
            case (state)
                SHIFT_IR: begin
                    tdo_q    <= shift_ir[0];
                    tdo_oe_q <= 1'b1;
                end
                SHIFT_DR: begin
                    tdo_q    <= dr_tdo;
                    tdo_oe_q <= 1'b1;
                end
                default:  tdo_oe_q <= 1'b0;
            endcase
        end
    end

    assign jtag.tdo_pad_o      = tdo_q;
    assign jtag.tdo_oe_o       = tdo_oe_q;
    assign jtag.debug_select_o = dbg_sel;
    assign jtag.capture_dr_o   = capture_q;
    assign jtag.shift_dr_o     = shift_q;
    assign jtag.update_dr_o    = update_q;
    assign jtag.debug_tdi_o    = debug_tdi_q;

endmodule
